hworld_seq: RTL and testbench

HWORLD_SEQ -- requirements
Module: hworld_seq

---
 rtl/hworld_seq.sv | 122 ++++++++++++
 tb/tb_hworld_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hworld_seq.sv
// Adder-offload sequencer: writes operands to a bus-attached adder register
// block, reads back sum and carry, and returns them on a valid/ready port.
module hworld_seq #(
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_a_i,
  input  logic [31:0] in_b_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_sum_o,
  output logic        out_cout_o,
  output logic        out_err_o,
  output logic        reg_req_o,
  output logic [31:0] reg_addr_o,
  output logic        reg_we_o,
  output logic [31:0] reg_wdata_o,
  output logic [3:0]  reg_be_o,
  input  logic        reg_gnt_i,
  input  logic        reg_rvalid_i,
  input  logic [31:0] reg_rdata_i,
  output logic        busy_o
);

  typedef enum logic [3:0] {
    IDLE, REQ_A, RSP_A, REQ_B, RSP_B, REQ_S, RSP_S, REQ_C, RSP_C, OUT
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, next;
  logic [31:0] a_q, b_q, sum_q;
  logic        cout_q, err_q;
  logic [7:0]  cnt;
  logic        in_req, in_rsp, in_bus, enter_req, expired, abort, accept;

  assign in_req    = state inside {REQ_A, REQ_B, REQ_S, REQ_C};
  assign in_rsp    = state inside {RSP_A, RSP_B, RSP_S, RSP_C};
  assign in_bus    = in_req | in_rsp;
  assign enter_req = (next inside {REQ_A, REQ_B, REQ_S, REQ_C}) && (next != state);
  assign expired   = (cnt == CNT_LAST);
  assign accept    = (state == IDLE) && in_valid_i;

  assign in_ready_o  = (state == IDLE);
  assign busy_o      = (state != IDLE);
  assign out_valid_o = (state == OUT);
  assign out_sum_o   = sum_q;
  assign out_cout_o  = cout_q;
  assign out_err_o   = err_q;
  assign reg_req_o   = in_req;
  assign reg_be_o    = '1;

  always_comb begin
    reg_addr_o  = '0;
    reg_we_o    = 1'b0;
    reg_wdata_o = '0;
    unique case (state)
      REQ_A: begin reg_addr_o = BASE_ADDR;          reg_we_o = 1'b1; reg_wdata_o = a_q; end
      REQ_B: begin reg_addr_o = BASE_ADDR + 32'h4;  reg_we_o = 1'b1; reg_wdata_o = b_q; end
      REQ_S: reg_addr_o = BASE_ADDR + 32'h8;
      REQ_C: reg_addr_o = BASE_ADDR + 32'hC;
      default: ;
    endcase
  end

  always_comb begin
    next  = state;
    abort = 1'b0;
    unique case (state)
      IDLE:  if (in_valid_i)   next = REQ_A;
      REQ_A: if (reg_gnt_i)    next = RSP_A;
      RSP_A: if (reg_rvalid_i) next = REQ_B;
      REQ_B: if (reg_gnt_i)    next = RSP_B;
      RSP_B: if (reg_rvalid_i) next = REQ_S;
      REQ_S: if (reg_gnt_i)    next = RSP_S;
      RSP_S: if (reg_rvalid_i) next = REQ_C;
      REQ_C: if (reg_gnt_i)    next = RSP_C;
      RSP_C: if (reg_rvalid_i) next = OUT;
      OUT:   if (out_ready_i)  next = IDLE;
      default: next = IDLE;
    endcase
    // Expiry beats a same-cycle grant but loses to a same-cycle response.
    if (in_bus && expired && !(in_rsp && reg_rvalid_i)) begin
      abort = 1'b1;
      next  = OUT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      err_q  <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= next;
      if (enter_req)   cnt <= '0;
      else if (in_bus) cnt <= cnt + 8'd1;
      if (accept) begin
        a_q   <= in_a_i;
        b_q   <= in_b_i;
        err_q <= 1'b0;
      end
      if (abort) begin
        sum_q  <= '0;
        cout_q <= 1'b0;
        err_q  <= 1'b1;
      end else begin
        if (state == RSP_S && reg_rvalid_i) sum_q  <= reg_rdata_i;
        if (state == RSP_C && reg_rvalid_i) cout_q <= reg_rdata_i[0];
      end
    end
  end

endmodule

// File: tb/tb_hworld_seq.sv
// Bench for hworld_seq: a bus model that behaves as the adder register block,
// vector table, random pairs, back-to-back, reset abort and timeout cases.
module tb_hworld_seq;

  localparam logic [31:0] BASE = 32'h4000_1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, failed = 0;

  // main instance signals
  logic rst, in_valid, in_ready, out_valid, out_ready, out_cout, out_err;
  logic [31:0] in_a, in_b, out_sum, reg_addr, reg_wdata, reg_rdata;
  logic reg_req, reg_we, reg_gnt, reg_rvalid, busy;
  logic [3:0] reg_be;

  hworld_seq #(.BASE_ADDR(BASE)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_a_i(in_a), .in_b_i(in_b), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_sum_o(out_sum), .out_cout_o(out_cout), .out_err_o(out_err),
    .reg_req_o(reg_req), .reg_addr_o(reg_addr), .reg_we_o(reg_we),
    .reg_wdata_o(reg_wdata), .reg_be_o(reg_be), .reg_gnt_i(reg_gnt),
    .reg_rvalid_i(reg_rvalid), .reg_rdata_i(reg_rdata), .busy_o(busy));

  // short-timeout instance signals
  logic t_in_valid, t_in_ready, t_out_valid, t_out_ready, t_cout, t_err;
  logic [31:0] t_a, t_b, t_sum, t_addr, t_wdata, t_rdata;
  logic t_req, t_we, t_gnt, t_rvalid, t_busy;
  logic [3:0] t_be;

  hworld_seq #(.TIMEOUT_CYCLES(4)) dut_t (
    .clk_i(clk), .rst_i(rst), .in_valid_i(t_in_valid), .in_ready_o(t_in_ready),
    .in_a_i(t_a), .in_b_i(t_b), .out_valid_o(t_out_valid), .out_ready_i(t_out_ready),
    .out_sum_o(t_sum), .out_cout_o(t_cout), .out_err_o(t_err),
    .reg_req_o(t_req), .reg_addr_o(t_addr), .reg_we_o(t_we),
    .reg_wdata_o(t_wdata), .reg_be_o(t_be), .reg_gnt_i(t_gnt),
    .reg_rvalid_i(t_rvalid), .reg_rdata_i(t_rdata), .busy_o(t_busy));

  // Register block model: SUM/COUT reads derive from the last written A/B.
  function automatic logic [31:0] reg_model(input logic [31:0] off, input logic [31:0] x, y);
    logic [32:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (off == 32'h8) return s[31:0];
    if (off == 32'hC) return {31'b0, s[32]};
    return 32'h0;
  endfunction

  // main bus model with programmable grant and response delays
  int gnt_delay = 0, rsp_delay = 0, gnt_wait = 0, rsp_cnt = 0;
  bit pending = 1'b0;
  logic [31:0] ra = '0, rb = '0, rd_hold = '0;
  logic [68:0] log[$];
  assign reg_gnt    = reg_req && (gnt_wait >= gnt_delay);
  assign reg_rvalid = pending && (rsp_cnt == 0);
  assign reg_rdata  = rd_hold;
  always @(posedge clk) begin
    gnt_wait <= (reg_req && !reg_gnt) ? gnt_wait + 1 : 0;
    if (reg_req && reg_gnt) begin
      log.push_back({reg_addr, reg_we, reg_wdata, reg_be});
      if (reg_we && reg_addr == BASE)         ra <= reg_wdata;
      if (reg_we && reg_addr == BASE + 32'h4) rb <= reg_wdata;
      rd_hold <= reg_model(reg_addr - BASE, ra, rb);
      pending <= 1'b1;
      rsp_cnt <= rsp_delay;
    end else if (pending) begin
      if (rsp_cnt == 0) pending <= 1'b0;
      else rsp_cnt <= rsp_cnt - 1;
    end
  end

  // short-timeout bus model: immediate grant, optional dropped B-write response
  int t_rd = 0, t_cnt = 0, t_reads = 0;
  bit t_drop = 1'b0, t_pend = 1'b0;
  logic [31:0] ta_r = '0, tb_r = '0, t_hold = '0;
  assign t_gnt    = t_req;
  assign t_rvalid = t_pend && (t_cnt == 0);
  assign t_rdata  = t_hold;
  always @(posedge clk) begin
    if (t_req) begin
      if (!t_we) t_reads <= t_reads + 1;
      if (t_we && t_addr == 32'h0) ta_r <= t_wdata;
      if (t_we && t_addr == 32'h4) tb_r <= t_wdata;
      t_hold <= reg_model(t_addr, ta_r, tb_r);
      if (!(t_drop && t_we && t_addr == 32'h4)) begin
        t_pend <= 1'b1;
        t_cnt  <= t_rd;
      end
    end else if (t_pend) begin
      if (t_cnt == 0) t_pend <= 1'b0;
      else t_cnt <= t_cnt - 1;
    end
  end

  // request fields must not move while a request waits for its grant
  int stab_bad = 0;
  logic p_wait = 1'b0;
  logic [68:0] p_fields = '0;
  always @(negedge clk) begin
    if (p_wait && (!reg_req || {reg_addr, reg_we, reg_wdata, reg_be} !== p_fields)) stab_bad++;
    p_wait   = reg_req && !reg_gnt && !rst;
    p_fields = {reg_addr, reg_we, reg_wdata, reg_be};
  end

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic check_log(input string nm, input logic [31:0] a, b);
    logic [31:0] wd;
    chk({nm, "_txn_count"}, 80'(log.size()), 80'd4);
    if (log.size() == 4)
      for (int i = 0; i < 4; i++) begin
        wd = (i == 0) ? a : (i == 1) ? b : 32'h0;
        chk($sformatf("%s_txn%0d", nm, i), 80'(log[i]),
            80'({BASE + 32'(4 * i), (i < 2), wd, 4'hF}));
      end
  endtask

  task automatic run_pair(input string nm, input logic [31:0] a, b, input int gd, rd, rdy, lat,
                          input logic [31:0] esum, input logic ecout);
    int c0, n, ir_bad, hold_bad;
    logic [31:0] s0;
    gnt_delay = gd; rsp_delay = rd; log.delete();
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    in_a = a; in_b = b; in_valid = 1'b1; c0 = cyc;
    @(negedge clk);
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
    ir_bad = 0; n = 0;
    while (!out_valid && n < 300) begin
      if (in_ready) ir_bad++;
      @(negedge clk); n++;
    end
    chk({nm, "_ready_low"}, 80'(ir_bad), 80'd0);
    chk({nm, "_latency"}, 80'(cyc - c0), 80'(lat));
    chk({nm, "_sum"}, 80'(out_sum), 80'(esum));
    chk({nm, "_cout_err"}, 80'({out_cout, out_err}), 80'({ecout, 1'b0}));
    s0 = out_sum; hold_bad = 0;
    repeat (rdy) begin
      @(negedge clk);
      if (!out_valid || in_ready || out_sum !== s0 || out_cout !== ecout) hold_bad++;
    end
    chk({nm, "_hold"}, 80'(hold_bad), 80'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "_idle"}, 80'({out_valid, in_ready, busy, reg_req}), 80'(4'b0100));
    chk({nm, "_sum_kept"}, 80'(out_sum), 80'(s0));
    check_log(nm, a, b);
  endtask

  task automatic t_pair(input string nm, input logic [31:0] a, b, input int rd, input bit drop,
                        input int lat, input logic ee, input logic [31:0] es, input logic ec);
    int c0, n, r0;
    t_rd = rd; t_drop = drop; r0 = t_reads;
    n = 0;
    while (!t_in_ready && n < 50) begin @(negedge clk); n++; end
    t_a = a; t_b = b; t_in_valid = 1'b1; c0 = cyc;
    @(negedge clk);
    t_in_valid = 1'b0;
    chk({nm, "_err_cleared"}, 80'(t_err), 80'd0);
    n = 0;
    while (!t_out_valid && n < 100) begin @(negedge clk); n++; end
    chk({nm, "_latency"}, 80'(cyc - c0), 80'(lat));
    chk({nm, "_result"}, 80'({t_err, t_cout, t_sum}), 80'({ee, ec, es}));
    if (drop) chk({nm, "_no_reads"}, 80'(t_reads - r0), 80'd0);
    t_out_ready = 1'b1;
    @(negedge clk);
    t_out_ready = 1'b0;
    chk({nm, "_err_kept"}, 80'({t_out_valid, t_err}), 80'({1'b0, ee}));
  endtask

  typedef struct {
    logic [31:0] a, b;
    int gd, rd, rdy;
    logic [31:0] sum;
    logic cout;
    int lat;
  } vec_t;
  vec_t vecs[4];

  initial begin
    logic [31:0] a, b, bb_a[3], bb_b[3];
    logic [32:0] s;
    int gd, rd, acc, res, last_out, n, bad;
    bit just_acc;

    vecs[0] = '{32'h0000_0005, 32'h0000_0007, 0, 0, 0, 32'h0000_000C, 1'b0, 9};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 0, 32'h0000_0000, 1'b1, 9};
    vecs[2] = '{32'h1234_5678, 32'h1111_1111, 3, 0, 5, 32'h2345_6789, 1'b0, 21};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1, 1, 2, 32'h0000_0000, 1'b1, 17};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    t_in_valid = 1'b0; t_a = '0; t_b = '0; t_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 80'({reg_req, out_valid, busy, in_ready, out_cout, out_err, out_sum}),
        80'({6'b000100, 32'h0}));
    chk("reset_counter", 80'(dut.cnt), 80'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++)
      run_pair($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].gd, vecs[i].rd,
               vecs[i].rdy, vecs[i].lat, vecs[i].sum, vecs[i].cout);

    for (int i = 0; i < 12; i++) begin
      a = $urandom; b = $urandom;
      if (i % 4 == 1) a = 32'hFFFF_FFFF;
      gd = $urandom_range(0, 3); rd = $urandom_range(0, 2);
      s = {1'b0, a} + {1'b0, b};
      run_pair($sformatf("rnd%0d", i), a, b, gd, rd, $urandom_range(0, 3),
               1 + 4 * (2 + gd + rd), s[31:0], s[32]);
    end

    // back-to-back: in_valid held, out_ready held
    gnt_delay = 0; rsp_delay = 0;
    for (int i = 0; i < 3; i++) begin bb_a[i] = $urandom; bb_b[i] = $urandom; end
    in_a = bb_a[0]; in_b = bb_b[0]; in_valid = 1'b1; out_ready = 1'b1;
    acc = 0; res = 0; last_out = 0; just_acc = 1'b0; n = 0;
    while (res < 3 && n < 100) begin
      if (just_acc) begin
        if (acc < 3) begin in_a = bb_a[acc]; in_b = bb_b[acc]; end
        else in_valid = 1'b0;
        just_acc = 1'b0;
      end
      if (out_valid) begin
        s = {1'b0, bb_a[res]} + {1'b0, bb_b[res]};
        chk($sformatf("b2b%0d_result", res), 80'({out_err, out_cout, out_sum}), 80'({1'b0, s}));
        last_out = cyc; res++;
      end
      if (in_valid && in_ready) begin
        if (acc > 0) chk($sformatf("b2b%0d_accept_gap", acc), 80'(cyc - last_out), 80'd1);
        acc++; just_acc = 1'b1;
      end
      @(negedge clk); n++;
    end
    chk("b2b_count", 80'(res), 80'd3);
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);

    // reset while waiting for the SUM read response
    gnt_delay = 0; rsp_delay = 5; log.delete();
    in_a = 32'h0000_0100; in_b = 32'h0000_0200; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; n = 0;
    while (log.size() < 3 && n < 40) begin @(negedge clk); n++; end
    chk("rst_reached_rsp_s", 80'(log.size()), 80'd3);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_abort", 80'({reg_req, out_valid, busy, in_ready, out_sum}), 80'({4'b0001, 32'h0}));
    rst = 1'b0; bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (reg_req || out_valid || busy || !in_ready) bad++;
    end
    chk("rst_late_rvalid_ignored", 80'(bad), 80'd0);
    chk("rst_no_more_bus", 80'(log.size()), 80'd3);
    chk("req_fields_stable", 80'(stab_bad), 80'd0);

    // short-timeout instance
    t_pair("t_basic", 32'd20, 32'd22, 0, 1'b0, 9, 1'b0, 32'd42, 1'b0);
    t_pair("t_timeout", 32'd3, 32'd4, 0, 1'b1, 7, 1'b1, 32'd0, 1'b0);
    t_pair("t_recover", 32'hFFFF_FFFE, 32'd3, 0, 1'b0, 9, 1'b0, 32'd1, 1'b1);
    t_pair("t_rvalid_wins", 32'd9, 32'd10, 2, 1'b0, 17, 1'b0, 32'd19, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
